// File: rtl/fb_pkg.sv
// Shared framebuffer constants and state encoding for the VGA write path.
// Used by the write arbiter, the text renderer and the vga block.
package fb_pkg;
  localparam int PIXEL_WIDTH  = 640;
  localparam int PIXEL_HEIGHT = 480;
  localparam int PIXEL_COUNT  = PIXEL_WIDTH * PIXEL_HEIGHT;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 8;

  localparam logic [DATA_W-1:0] WHITE = 8'hFF;
  localparam logic [DATA_W-1:0] BLACK = 8'h00;

  typedef enum logic {IDLE, CLEAR} fb_state_t;
endpackage

// File: rtl/fb_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: combinational grant plus the last-winner register.
// A grant is only ever raised for a valid requester, so grant doubles as "transfer".
module rr_arbiter2 (
  input  logic       pclk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset)       last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Muxes two pixel-write requesters and a full-frame clear engine onto the single
// framebuffer write port; all framebuffer outputs are registered (1-cycle latency).
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                PIXEL_COUNT = fb_pkg::PIXEL_COUNT,
  parameter int                ADDR_W      = fb_pkg::ADDR_W,
  parameter int                DATA_W      = fb_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              fb_wr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              oob_err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_COUNT - 1);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(PIXEL_COUNT);

  fb_state_t         state, state_nxt;
  logic              enable;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr, addr_nxt;
  logic [DATA_W-1:0] sel_data, data_nxt;
  logic              wr_nxt, oob_nxt;

  assign enable     = (state == IDLE) && !clear_req && !reset;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign clear_busy = (state == CLEAR);
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  rr_arbiter2 u_arb (
    .pclk   (pclk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .enable (enable),
    .grant  (grant)
  );

  // fb_addr doubles as the clear counter: the first clear write is launched
  // straight from IDLE so clear_busy and the clear writes line up cycle for cycle.
  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    addr_nxt  = fb_addr;
    data_nxt  = fb_data;
    oob_nxt   = oob_err;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          wr_nxt    = 1'b1;
          addr_nxt  = '0;
          data_nxt  = CLEAR_COLOR;
        end else if (|grant) begin
          if (sel_addr < END_ADDR) begin
            wr_nxt   = 1'b1;
            addr_nxt = sel_addr;
            data_nxt = sel_data;
          end else begin
            oob_nxt  = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (fb_addr == LAST_ADDR) begin
          state_nxt = IDLE;
        end else begin
          wr_nxt   = 1'b1;
          addr_nxt = fb_addr + ADDR_W'(1);
          data_nxt = CLEAR_COLOR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state   <= IDLE;
      fb_wr   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      oob_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      fb_wr   <= wr_nxt;
      fb_addr <= addr_nxt;
      fb_data <= data_nxt;
      oob_err <= oob_nxt;
    end
  end
endmodule
